pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage pipeline (F/D/E/M/W).
//  - Generates E-stage forwarding selects.
//  - Generates load-use stalls and branch/jump flushes.
//  - Sequences multi-cycle execute ops (MUL/DIV unit) via a start/done
//    handshake, freezing F/D/E and bubbling M while the unit is busy.
//  - A watchdog flags a unit that never completes.
// PARAMETERS
//  REG_AW       5    register-address width
//  MDU_TIMEOUT  64   max BUSY cycles before watchdog trips (>=2)
// PORTS
//  clk          in   1       core clock, all state on rising edge
//  rst_n        in   1       synchronous reset, active-low
//  rs1_d,rs2_d  in   REG_AW  source regs of instr in D
//  rs1_e,rs2_e  in   REG_AW  source regs of instr in E
//  rd_e,rd_m,rd_w in REG_AW  dest regs in E/M/W
//  load_e       in   1       instr in E is a load (result_src = memory)
//  reg_write_m  in   1       instr in M writes rd_m
//  reg_write_w  in   1       instr in W writes rd_w
//  pc_src_e     in   1       taken branch/jump resolved in E
//  mdu_op_e     in   1       instr in E is a multi-cycle MDU op
//  mdu_done     in   1       MDU result valid this cycle (1-cycle pulse)
//  forward_a_e  out  2       00 regfile, 01 W result, 10 M ALU result
//  forward_b_e  out  2       same encoding for rs2_e
//  stall_f,stall_d,stall_e out 1  hold F/D/E pipeline registers
//  flush_d,flush_e,flush_m out 1  clear D/E/M pipeline registers (bubble)
//  mdu_start    out  1       1-cycle pulse launching the MDU
//  mdu_busy     out  1       FSM in BUSY
//  mdu_timeout  out  1       sticky watchdog error
// BEHAVIOUR
//  Forwarding (comb):
//   - 10 if reg_write_m && rd_m==rs1_e && rs1_e!=0.
//   - else 01 if reg_write_w && rd_w==rs1_e && rs1_e!=0.
//   - else 00. M beats W. Same rule for rs2_e.
//  Load-use:
//   - lw_stall = load_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
//   - Effect: stall_f=stall_d=1, flush_e=1 for that cycle.
//  FSM (states IDLE, BUSY; 1-bit state reg plus cycle counter):
//   - IDLE, mdu_op_e=1: mdu_start=1, mdu_hold=1; next BUSY, cnt<=0.
//   - BUSY, mdu_done=0: mdu_hold=1, cnt<=cnt+1.
//     If cnt==MDU_TIMEOUT-1: mdu_timeout<=1, next IDLE.
//   - BUSY, mdu_done=1: mdu_hold=0 (E advances on this edge); next IDLE.
//   - mdu_busy = (state==BUSY).
//   - Back-to-back MDU ops: next op seen in IDLE, restarts immediately.
//  mdu_hold effect:
//   - stall_f=stall_d=stall_e=1, flush_m=1.
//   - flush_d=flush_e=0: lw_stall and pc_src_e are ignored while holding.
//  Branch (no hold): flush_d=pc_src_e; flush_e=pc_src_e|lw_stall.
//   - pc_src_e together with lw_stall: flush both; F/D stall still applies.
//  Counter width: $clog2(MDU_TIMEOUT+1); never wraps (watchdog exits first).
//  Reset (rst_n=0 at edge):
//   - state<=IDLE, cnt<=0, mdu_timeout<=0.
//   - While rst_n=0: mdu_start=0, all stalls 0, flush_d=flush_e=flush_m=1.
//   - Reset mid-BUSY abandons the op; a late mdu_done in IDLE is ignored.
//  mdu_timeout stays 1 until reset; the pipeline resumes after the trip.
// TESTING
//  1 rd_m=5,reg_write_m=1,rd_w=5,reg_write_w=1,rs1_e=5 -> forward_a_e=10;
//    rs1_e=0 -> 00.
//  2 load_e=1,rd_e=7,rs2_d=7 -> stall_f=stall_d=flush_e=1 for 1 cycle;
//    rd_e=0 -> no stall.
//  3 mdu_op_e=1, mdu_done after 4 cycles -> mdu_start=1 for cycle 0 only;
//    stalls held 5 cycles; flush_m=1 throughout; IDLE after done.
//  4 pc_src_e=1 and lw_stall in same cycle -> flush_d=flush_e=1,
//    stall_f=stall_d=1; pc_src_e=1 during BUSY -> no flush.
//  5 MDU_TIMEOUT=8, mdu_done never -> mdu_timeout=1 after 8 BUSY cycles;
//    stalls drop; flag stays sticky until rst_n=0.
//  6 rst_n=0 mid-BUSY, then mdu_done pulse after release -> IDLE, no stall,
//    no mdu_start.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the F/D/E/M/W pipeline: E-stage forwarding,
// load-use stalls, branch flushes and a start/done sequencer for the MDU.
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              load_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              pc_src_e,
  input  logic              mdu_op_e,
  input  logic              mdu_done,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              mdu_start,
  output logic              mdu_busy,
  output logic              mdu_timeout
);

  localparam int CW = $clog2(MDU_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MDU_TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          trip, hold, lw_stall;

  // M-stage producer is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (reg_write_m && rd_m == rs && rs != '0)      fwd_sel = 2'b10;
    else if (reg_write_w && rd_w == rs && rs != '0) fwd_sel = 2'b01;
    else                                            fwd_sel = 2'b00;
  endfunction

  assign forward_a_e = fwd_sel(rs1_e);
  assign forward_b_e = fwd_sel(rs2_e);
  assign lw_stall    = load_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (trip) mdu_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    trip    = 1'b0;
    case (state)
      IDLE: if (mdu_op_e) begin
        state_n = BUSY;
        cnt_n   = '0;
      end
      BUSY: if (mdu_done) begin
        state_n = IDLE;
      end else if (cnt == CNT_LAST) begin
        trip    = 1'b1;
        state_n = IDLE;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Reset forces bubbles everywhere and suppresses stalls and MDU launch.
  always_comb begin
    hold      = (state == IDLE) ? mdu_op_e : !mdu_done;
    mdu_busy  = (state == BUSY);
    mdu_start = rst_n && state == IDLE && mdu_op_e;
    stall_f   = rst_n && (hold || lw_stall);
    stall_d   = rst_n && (hold || lw_stall);
    stall_e   = rst_n && hold;
    flush_d   = !rst_n || (!hold && pc_src_e);
    flush_e   = !rst_n || (!hold && (pc_src_e || lw_stall));
    flush_m   = !rst_n || hold;
  end

endmodule
